// File: rtl/oq_defs_pkg.sv
// Shared definitions for the output-queue empty tracker and scheduler.
package oq_defs_pkg;

  function automatic int unsigned log2(int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned NUM_OUTPUT_QUEUES_DEF = 8;
  localparam int unsigned NUM_OQ_WIDTH_DEF      = log2(NUM_OUTPUT_QUEUES_DEF);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOffer = 2'd1,
    StBusy  = 2'd2
  } oq_sched_state_e;

endpackage

// File: rtl/oq_regs_eval_empty_sched_if.sv
// Offer/accept handshake between the empty scheduler and the OQ reader.
interface oq_regs_eval_empty_sched_if #(
  parameter int unsigned NUM_OQ_WIDTH = oq_defs_pkg::NUM_OQ_WIDTH_DEF
) ();

  logic                    next_oq_valid;
  logic [NUM_OQ_WIDTH-1:0] next_oq;
  logic                    next_oq_accept;

  modport master (output next_oq_valid, output next_oq, input next_oq_accept);
  modport slave  (input next_oq_valid, input next_oq, output next_oq_accept);

endinterface

// File: rtl/oq_rr_pick.sv
// Combinational picker: rotating priority starting after the pointer, or lowest index
// when OQ_EMPTY_SCHED_STRICT_PRIO_EN is defined.
module oq_rr_pick #(
  parameter int unsigned NUM_OUTPUT_QUEUES = oq_defs_pkg::NUM_OUTPUT_QUEUES_DEF,
  parameter int unsigned NUM_OQ_WIDTH      = oq_defs_pkg::NUM_OQ_WIDTH_DEF
) (
  input  logic [NUM_OUTPUT_QUEUES-1:0] eligible,
  input  logic [NUM_OQ_WIDTH-1:0]      pointer,
  output logic                         found,
  output logic [NUM_OQ_WIDTH-1:0]      index
);

  logic [NUM_OQ_WIDTH-1:0] cand;

`ifdef OQ_EMPTY_SCHED_STRICT_PRIO_EN
  logic unused_pointer;
  assign unused_pointer = ^pointer;

  // Scan downwards so the last hit is the lowest index.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = NUM_OUTPUT_QUEUES; i >= 1; i--) begin
      cand = NUM_OQ_WIDTH'(i - 1);
      if (eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
`else
  // Scan distance N..1 from the pointer so the last hit is the nearest after it.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = NUM_OUTPUT_QUEUES; i >= 1; i--) begin
      cand = NUM_OQ_WIDTH'((32'(pointer) + i) % NUM_OUTPUT_QUEUES);
      if (eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/oq_regs_eval_empty_sched.sv
// Per-queue empty tracking plus single-outstanding grant scheduler for the OQ reader.
// Define OQ_EMPTY_SCHED_STRICT_PRIO_EN for lowest-index-first picking instead of round-robin.
module oq_regs_eval_empty_sched
  import oq_defs_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT_QUEUES = NUM_OUTPUT_QUEUES_DEF,
  parameter int unsigned NUM_OQ_WIDTH      = NUM_OQ_WIDTH_DEF,
  parameter int unsigned PKTS_IN_RAM_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dst_update,
  input  logic [NUM_OQ_WIDTH-1:0]      dst_oq,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q,
  input  logic                         dst_num_pkts_in_q_done,
  input  logic                         src_update,
  input  logic [NUM_OQ_WIDTH-1:0]      src_oq,
  input  logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q,
  input  logic                         src_num_pkts_in_q_done,
  input  logic                         initialize,
  input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq,
  input  logic [NUM_OUTPUT_QUEUES-1:0] oq_enable,
  output logic [NUM_OUTPUT_QUEUES-1:0] empty,
  oq_regs_eval_empty_sched_if.master   sched
);

  logic [NUM_OQ_WIDTH-1:0]      dst_oq_held, src_oq_held;
  logic [NUM_OUTPUT_QUEUES-1:0] empty_q, empty_d;
  logic [NUM_OUTPUT_QUEUES-1:0] in_service, eligible;
  logic [NUM_OQ_WIDTH-1:0]      ptr_q, next_oq_q, pick_idx;
  logic                         next_oq_valid_q, pick_found;
  logic                         init_hit, src_done_hit;
  oq_sched_state_e              state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dst_oq_held <= '0;
      src_oq_held <= '0;
    end else begin
      if (dst_update) dst_oq_held <= dst_oq;
      if (src_update) src_oq_held <= src_oq;
    end
  end

  // Later writes override earlier ones: initialize < remove < store.
  always_comb begin
    empty_d = empty_q;
    if (initialize) empty_d[initialize_oq] = 1'b1;
    if (src_num_pkts_in_q_done) empty_d[src_oq_held] = (src_num_pkts_in_q == '0);
    if (dst_num_pkts_in_q_done) empty_d[dst_oq_held] = (dst_num_pkts_in_q == '0);
    if (src_num_pkts_in_q_done && dst_num_pkts_in_q_done && (src_oq_held == dst_oq_held)) begin
      empty_d[dst_oq_held] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) empty_q <= '1;
    else          empty_q <= empty_d;
  end

  always_comb begin
    in_service = '0;
    if (state_q != StIdle) in_service[next_oq_q] = 1'b1;
  end

  assign eligible     = ~empty_q & oq_enable & ~in_service;
  assign init_hit     = initialize && (initialize_oq == next_oq_q);
  assign src_done_hit = src_num_pkts_in_q_done && (src_oq_held == next_oq_q);

  oq_rr_pick #(
    .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
    .NUM_OQ_WIDTH      (NUM_OQ_WIDTH)
  ) u_pick (
    .eligible (eligible),
    .pointer  (ptr_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      next_oq_valid_q <= 1'b0;
      next_oq_q       <= '0;
      ptr_q           <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            next_oq_q       <= pick_idx;
            next_oq_valid_q <= 1'b1;
            state_q         <= StOffer;
          end
        end
        StOffer: begin
          if (sched.next_oq_accept) begin
            ptr_q           <= next_oq_q;
            next_oq_valid_q <= 1'b0;
            state_q         <= StBusy;
          end else if (init_hit) begin
            next_oq_valid_q <= 1'b0;
            state_q         <= StIdle;
          end
        end
        StBusy: begin
          if (src_done_hit || init_hit) state_q <= StIdle;
        end
        default: begin
          next_oq_valid_q <= 1'b0;
          state_q         <= StIdle;
        end
      endcase
    end
  end

  assign empty               = empty_q;
  assign sched.next_oq_valid = next_oq_valid_q;
  assign sched.next_oq       = next_oq_q;

endmodule
